// File: rtl/reaction_ctrl_multi.sv
// rtl/reaction_ctrl_multi.sv - multi-player reaction-game round sequencer
// Random pre-stimulus delay, foul detection, ms reaction timing, winner arbitration, best-time register.
module reaction_ctrl_multi #(
  parameter int NUM_PLAYERS = 2,
  parameter int CNT_W       = 14,
  parameter int TICK_DIV    = 50000,
  parameter int MIN_DELAY   = 500,
  parameter int DELAY_W     = 12,
  parameter int TIMEOUT     = 9999,
  localparam int PW         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_PLAYERS-1:0] stop,
  input  logic                   show_high,
  input  logic                   clear_high,
  output logic                   stim_led,
  output logic                   timing,
  output logic [CNT_W-1:0]       result_ms,
  output logic                   result_valid,
  output logic                   timeout,
  output logic [PW-1:0]          winner,
  output logic                   foul,
  output logic [PW-1:0]          foul_player,
  output logic [CNT_W-1:0]       high_score,
  output logic                   high_enable,
  output logic [2:0]             state_out
);
  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int DLY_W = $clog2(MIN_DELAY + 2**DELAY_W) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    TIMING  = 3'd2,
    DONE    = 3'd3,
    FOUL    = 3'd4,
    HISCORE = 3'd5
  } state_t;

  state_t state, next_state;

  logic [15:0]            lfsr;
  logic [PS_W-1:0]        presc;
  logic [DLY_W-1:0]       delay;
  logic [CNT_W-1:0]       count;
  logic                   start_q;
  logic [NUM_PLAYERS-1:0] stop_q;
  logic                   timeout_q;

  logic                   start_edge;
  logic [NUM_PLAYERS-1:0] stop_edge;
  logic                   any_stop;
  logic                   tick;
  logic [PW-1:0]          stop_idx;

  logic load_delay, clr_presc, clr_count;
  logic latch_press, latch_timeout, latch_foul, clr_high;

  assign start_edge = start & ~start_q;
  assign stop_edge  = stop & ~stop_q;
  assign any_stop   = |stop_edge;
  assign tick       = (presc == PS_W'(TICK_DIV - 1));

  // Lowest-numbered player wins ties.
  always_comb begin
    stop_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (stop_edge[i]) stop_idx = PW'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    load_delay    = 1'b0;
    clr_presc     = 1'b0;
    clr_count     = 1'b0;
    latch_press   = 1'b0;
    latch_timeout = 1'b0;
    latch_foul    = 1'b0;
    clr_high      = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          next_state = ARMED;
          load_delay = 1'b1;
          clr_presc  = 1'b1;
        end else if (show_high) begin
          next_state = HISCORE;
        end else if (clear_high) begin
          clr_high = 1'b1;
        end
      end
      ARMED: begin
        if (any_stop) begin
          next_state = FOUL;
          latch_foul = 1'b1;
        end else if (tick && delay <= DLY_W'(1)) begin
          next_state = TIMING;
          clr_presc  = 1'b1;
          clr_count  = 1'b1;
        end
      end
      TIMING: begin
        if (any_stop) begin
          next_state  = DONE;
          latch_press = 1'b1;
        end else if (tick && count >= CNT_W'(TIMEOUT - 1)) begin
          next_state    = DONE;
          latch_timeout = 1'b1;
        end
      end
      DONE, FOUL: begin
        if (start_edge) begin
          next_state = ARMED;
          load_delay = 1'b1;
          clr_presc  = 1'b1;
        end
      end
      HISCORE: begin
        if (!show_high) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr         <= 16'hACE1;
      presc        <= '0;
      delay        <= '0;
      count        <= '0;
      start_q      <= 1'b0;
      stop_q       <= '0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      timeout_q    <= 1'b0;
      winner       <= '0;
      foul_player  <= '0;
      high_score   <= '1;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      start_q <= start;
      stop_q  <= stop;

      if (clr_presc || tick) presc <= '0;
      else                   presc <= presc + 1'b1;

      if (load_delay)                 delay <= DLY_W'(MIN_DELAY) + DLY_W'(lfsr[DELAY_W-1:0]);
      else if (state == ARMED && tick) delay <= delay - 1'b1;

      if (clr_count)                    count <= '0;
      else if (state == TIMING && tick) count <= count + 1'b1;

      if (latch_press) begin
        result_ms <= count;
        winner    <= stop_idx;
        timeout_q <= 1'b0;
      end else if (latch_timeout) begin
        result_ms <= CNT_W'(TIMEOUT);
        winner    <= '0;
        timeout_q <= 1'b1;
      end

      if (latch_foul) foul_player <= stop_idx;

      result_valid <= latch_press | latch_timeout;

      // Best time is compared during the single result_valid cycle; ties keep the old record.
      if (clr_high) high_score <= '1;
      else if (result_valid && !timeout_q && result_ms < high_score) high_score <= result_ms;
    end
  end

  assign stim_led    = (state == TIMING) || (state == DONE);
  assign timing      = (state == TIMING);
  assign foul        = (state == FOUL);
  assign high_enable = (state == HISCORE);
  assign timeout     = timeout_q && (state == DONE);
  assign state_out   = state;

endmodule

// File: tb/tb_reaction_ctrl_multi.sv
// tb/tb_reaction_ctrl_multi.sv - directed self-checking bench for reaction_ctrl_multi
module tb_reaction_ctrl_multi;
  localparam int NP   = 4;
  localparam int CW   = 14;
  localparam int TD   = 4;
  localparam int MIND = 3;
  localparam int DW   = 2;
  localparam int TO   = 20;
  localparam logic [CW-1:0] NONE = '1;

  logic          clock, reset, start, show_high, clear_high;
  logic [NP-1:0] stop;
  logic          stim_led, timing, result_valid, timeout, foul, high_enable;
  logic [CW-1:0] result_ms, high_score;
  logic [1:0]    winner, foul_player;
  logic [2:0]    state_out;
  logic [15:0]   m;

  int checks = 0;
  int errors = 0;

  reaction_ctrl_multi #(
    .NUM_PLAYERS(NP), .CNT_W(CW), .TICK_DIV(TD),
    .MIN_DELAY(MIND), .DELAY_W(DW), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .show_high(show_high), .clear_high(clear_high),
    .stim_led(stim_led), .timing(timing), .result_ms(result_ms),
    .result_valid(result_valid), .timeout(timeout), .winner(winner),
    .foul(foul), .foul_player(foul_player), .high_score(high_score),
    .high_enable(high_enable), .state_out(state_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference LFSR used to predict the random delay of each round.
  always @(posedge clock or posedge reset) begin
    if (reset) m <= 16'hACE1;
    else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic begin_round(input int want, output int d);
    if (want >= 0) begin
      for (int k = 0; k < 64 && m[1:0] != want[1:0]; k++) cyc(1);
      checks++;
      if (m[1:0] !== want[1:0]) begin
        errors++;
        $display("FAIL lfsr_wait low_bits=%0d expected=%0d", m[1:0], want[1:0]);
      end
    end
    d = MIND + int'(m[1:0]);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic press_after(input int d, input int r, input logic [NP-1:0] pat);
    cyc(4 * d + 4 * r);
    stop = pat;
    cyc(1);
    stop = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; stop = '0; show_high = 1'b0; clear_high = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; stop = '0; show_high = 1'b0; clear_high = 1'b0;
    cyc(3);
    checks++;
    if (state_out !== 3'd0 || stim_led !== 1'b0 || timing !== 1'b0 || result_valid !== 1'b0 ||
        timeout !== 1'b0 || foul !== 1'b0 || high_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl state=%0d stim=%b timing=%b valid=%b to=%b foul=%b hen=%b expected 0", state_out,
               stim_led, timing, result_valid, timeout, foul, high_enable);
    end
    checks++;
    if (result_ms !== '0 || winner !== 2'd0 || foul_player !== 2'd0 || high_score !== NONE) begin
      errors++;
      $display("FAIL reset_data result=%0d winner=%0d fp=%0d high=%h expected 0/0/0/3fff", result_ms, winner,
               foul_player, high_score);
    end
    reset = 1'b0;
    cyc(2);
    checks++;
    if (state_out !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle state=%0d expected=0", state_out);
    end
  endtask

  task automatic test_hiscore();
    show_high = 1'b1;
    cyc(1);
    checks++;
    if (state_out !== 3'd5 || high_enable !== 1'b1) begin
      errors++;
      $display("FAIL hiscore_enter state=%0d hen=%b expected 5/1", state_out, high_enable);
    end
    start = 1'b1; stop = 4'b1111;
    cyc(1);
    start = 1'b0; stop = '0;
    cyc(1);
    checks++;
    if (state_out !== 3'd5) begin
      errors++;
      $display("FAIL hiscore_ignore state=%0d expected=5", state_out);
    end
    show_high = 1'b0;
    cyc(1);
    checks++;
    if (state_out !== 3'd0 || high_enable !== 1'b0) begin
      errors++;
      $display("FAIL hiscore_exit state=%0d hen=%b expected 0/0", state_out, high_enable);
    end
    clear_high = 1'b1;
    cyc(1);
    clear_high = 1'b0;
    checks++;
    if (state_out !== 3'd0 || high_score !== NONE) begin
      errors++;
      $display("FAIL hiscore_clear state=%0d high=%h expected 0/3fff", state_out, high_score);
    end
    start = 1'b1; show_high = 1'b1;
    cyc(1);
    start = 1'b0; show_high = 1'b0;
    checks++;
    if (state_out !== 3'd1) begin
      errors++;
      $display("FAIL start_over_show state=%0d expected=1", state_out);
    end
    do_reset();
  endtask

  task automatic test_normal_round();
    int d;
    begin_round(1, d);
    checks++;
    if (state_out !== 3'd1 || stim_led !== 1'b0) begin
      errors++;
      $display("FAIL normal_armed state=%0d stim=%b expected 1/0", state_out, stim_led);
    end
    cyc(4 * d - 1);
    checks++;
    if (stim_led !== 1'b0 || state_out !== 3'd1) begin
      errors++;
      $display("FAIL normal_early_stim stim=%b state=%0d expected 0/1", stim_led, state_out);
    end
    cyc(1);
    checks++;
    if (stim_led !== 1'b1 || timing !== 1'b1 || state_out !== 3'd2) begin
      errors++;
      $display("FAIL normal_stim stim=%b timing=%b state=%0d expected 1/1/2", stim_led, timing, state_out);
    end
    press_after(0, 7, 4'b0100);
    checks++;
    if (state_out !== 3'd3 || result_ms !== 14'd7 || winner !== 2'd2 || result_valid !== 1'b1 ||
        timeout !== 1'b0 || high_score !== NONE) begin
      errors++;
      $display("FAIL normal_done state=%0d result=%0d winner=%0d valid=%b to=%b high=%h expected 3/7/2/1/0/3fff",
               state_out, result_ms, winner, result_valid, timeout, high_score);
    end
    cyc(1);
    checks++;
    if (result_valid !== 1'b0 || high_score !== 14'd7 || stim_led !== 1'b1) begin
      errors++;
      $display("FAIL normal_high valid=%b high=%0d stim=%b expected 0/7/1", result_valid, high_score, stim_led);
    end
    stop = 4'b0001; clear_high = 1'b1;
    cyc(1);
    stop = '0;
    cyc(1);
    clear_high = 1'b0;
    checks++;
    if (state_out !== 3'd3 || result_ms !== 14'd7 || winner !== 2'd2 || high_score !== 14'd7) begin
      errors++;
      $display("FAIL done_hold state=%0d result=%0d winner=%0d high=%0d expected 3/7/2/7", state_out, result_ms,
               winner, high_score);
    end
  endtask

  task automatic test_foul();
    int d;
    begin_round(-1, d);
    cyc(2);
    stop = 4'b0010;
    cyc(1);
    stop = '0;
    checks++;
    if (state_out !== 3'd4 || foul !== 1'b1 || foul_player !== 2'd1 || stim_led !== 1'b0 ||
        high_score !== 14'd7 || result_ms !== 14'd7) begin
      errors++;
      $display("FAIL foul_enter state=%0d foul=%b fp=%0d stim=%b high=%0d result=%0d expected 4/1/1/0/7/7",
               state_out, foul, foul_player, stim_led, high_score, result_ms);
    end
    cyc(3);
    checks++;
    if (state_out !== 3'd4) begin
      errors++;
      $display("FAIL foul_hold state=%0d expected=4", state_out);
    end
    begin_round(-1, d);
    checks++;
    if (state_out !== 3'd1 || foul !== 1'b0) begin
      errors++;
      $display("FAIL foul_restart state=%0d foul=%b expected 1/0", state_out, foul);
    end
    cyc(4 * d - 1);
    stop = 4'b0100;
    cyc(1);
    stop = '0;
    checks++;
    if (state_out !== 3'd4 || foul_player !== 2'd2) begin
      errors++;
      $display("FAIL foul_at_expiry state=%0d fp=%0d expected 4/2", state_out, foul_player);
    end
    begin_round(-1, d);
    press_after(d, 12, 4'b1000);
    cyc(1);
    checks++;
    if (state_out !== 3'd3 || result_ms !== 14'd12 || winner !== 2'd3 || high_score !== 14'd7) begin
      errors++;
      $display("FAIL slower_round state=%0d result=%0d winner=%0d high=%0d expected 3/12/3/7", state_out,
               result_ms, winner, high_score);
    end
  endtask

  task automatic test_simultaneous();
    int d;
    begin_round(-1, d);
    press_after(d, 5, 4'b1010);
    checks++;
    if (result_ms !== 14'd5 || winner !== 2'd1 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_press result=%0d winner=%0d valid=%b expected 5/1/1", result_ms, winner, result_valid);
    end
    cyc(1);
    checks++;
    if (high_score !== 14'd5) begin
      errors++;
      $display("FAIL simul_high high=%0d expected=5", high_score);
    end
    begin_round(-1, d);
    press_after(d, 9, 4'b0001);
    cyc(1);
    checks++;
    if (result_ms !== 14'd9 || winner !== 2'd0 || high_score !== 14'd5) begin
      errors++;
      $display("FAIL slower_keep result=%0d winner=%0d high=%0d expected 9/0/5", result_ms, winner, high_score);
    end
    begin_round(-1, d);
    press_after(d, 5, 4'b1000);
    cyc(1);
    checks++;
    if (result_ms !== 14'd5 || winner !== 2'd3 || high_score !== 14'd5) begin
      errors++;
      $display("FAIL equal_keep result=%0d winner=%0d high=%0d expected 5/3/5", result_ms, winner, high_score);
    end
  endtask

  task automatic test_timeout();
    int d;
    begin_round(-1, d);
    cyc(4 * d + 79);
    checks++;
    if (state_out !== 3'd2 || timing !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early state=%0d timing=%b expected 2/1", state_out, timing);
    end
    cyc(1);
    checks++;
    if (state_out !== 3'd3 || result_ms !== 14'd20 || timeout !== 1'b1 || result_valid !== 1'b1 ||
        winner !== 2'd0) begin
      errors++;
      $display("FAIL timeout_done state=%0d result=%0d to=%b valid=%b winner=%0d expected 3/20/1/1/0", state_out,
               result_ms, timeout, result_valid, winner);
    end
    cyc(1);
    checks++;
    if (high_score !== 14'd5 || result_valid !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_high high=%0d valid=%b to=%b expected 5/0/1", high_score, result_valid, timeout);
    end
  endtask

  task automatic test_reset_mid_timing();
    int d;
    begin_round(-1, d);
    cyc(4 * d + 8);
    checks++;
    if (state_out !== 3'd2) begin
      errors++;
      $display("FAIL midreset_pre state=%0d expected=2", state_out);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state_out !== 3'd0 || stim_led !== 1'b0 || timing !== 1'b0 || high_score !== NONE ||
        result_ms !== '0) begin
      errors++;
      $display("FAIL midreset_async state=%0d stim=%b timing=%b high=%h result=%0d expected 0/0/0/3fff/0",
               state_out, stim_led, timing, high_score, result_ms);
    end
    cyc(1);
    reset = 1'b0;
    cyc(2);
    checks++;
    if (state_out !== 3'd0) begin
      errors++;
      $display("FAIL midreset_idle state=%0d expected=0", state_out);
    end
  endtask

  initial begin
    test_reset();
    test_hiscore();
    test_normal_round();
    test_foul();
    test_simultaneous();
    test_timeout();
    test_reset_mid_timing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl_multi.md
Name: reaction_ctrl_multi

Overview:
- Parametrised successor to the single-player reaction-game controller.
- Sequences a complete round for up to NUM_PLAYERS players:
  - randomised pre-stimulus delay;
  - false-start (foul) detection;
  - millisecond reaction timing with timeout;
  - winner arbitration;
  - persistent best-time (high-score) register with display mode.
- Sits between the debounced/synchronised key and switch inputs and the BCD display path and LEDs.
- Replaces the external BCD start/stop trigger with an internal binary counter.

Parameters:
- NUM_PLAYERS, 2, number of stop buttons/players (1..8).
- CNT_W, 14, width of reaction-time counter and high-score register, in ms.
- TICK_DIV, 50000, clock cycles per 1 ms tick (≥2).
- MIN_DELAY, 500, minimum pre-stimulus delay in ms.
- DELAY_W, 12, number of random LFSR bits added to MIN_DELAY.
- TIMEOUT, 9999, reaction-count ceiling in ms (< 2^CNT_W − 1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  start/new-round key; synchronous level, edge-detected internally.
- stop  in  NUM_PLAYERS  per-player stop keys; synchronous levels, edge-detected internally.
- show_high  in  1  high-score display switch (level).
- clear_high  in  1  high-score clear key; level, acted on only in IDLE.
- stim_led  out  1  stimulus light; 1 in TIMING and DONE.
- timing  out  1  1 while the reaction counter runs.
- result_ms  out  CNT_W  latched reaction time.
- result_valid  out  1  one-cycle pulse on entry to DONE.
- timeout  out  1  set in DONE when the round ended by TIMEOUT.
- winner  out  max(1,$clog2(NUM_PLAYERS))  index of the winning player.
- foul  out  1  1 while in FOUL.
- foul_player  out  max(1,$clog2(NUM_PLAYERS))  index of the player who false-started.
- high_score  out  CNT_W  best time; all-ones means none recorded.
- high_enable  out  1  1 while in HISCORE; selects the high-score display mux.
- state_out  out  3  current state encoding (debug).

Behaviour:
- Reset values:
  - State IDLE (3'd0).
  - All 1-bit outputs 0; result_ms 0; winner 0; foul_player 0.
  - high_score all ones.
  - LFSR 16'hACE1; prescaler, delay and reaction counters 0.
  - Edge-detect history registers 0.
- Edge detection: an edge is an input that is 1 now and was 0 on the previous clock. Only edges advance the FSM.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every clock in every state.
- ms tick:
  - Prescaler counts 0..TICK_DIV−1; tick asserts in the cycle it equals TICK_DIV−1.
  - Prescaler clears on entry to ARMED and on entry to TIMING.
- States: IDLE=0, ARMED=1, TIMING=2, DONE=3, FOUL=4, HISCORE=5.
- IDLE:
  - start edge → ARMED; delay loads MIN_DELAY + lfsr[DELAY_W-1:0].
  - Else show_high=1 → HISCORE.
  - Else clear_high=1 → high_score set to all ones, stay in IDLE.
  - Priority: start > show_high > clear_high.
- ARMED:
  - Each tick decrements delay.
  - Any stop edge → FOUL; foul_player = lowest set index.
  - Delay == 1 on a tick → TIMING; counter = 0.
  - Stop edge in the same cycle as delay expiry → FOUL (foul wins).
- TIMING:
  - timing=1, stim_led=1; counter increments on each tick.
  - Stop edge → DONE; result_ms = counter value in that cycle (before any increment); winner = lowest set index; timeout=0.
  - Counter reaches TIMEOUT → DONE; result_ms = TIMEOUT; timeout=1; winner=0.
  - Stop edge coincident with reaching TIMEOUT → press wins, timeout=0.
- DONE:
  - result_valid pulses for exactly the first cycle in DONE.
  - In that same cycle, if timeout=0 and result_ms < high_score, high_score ← result_ms. It is visible one cycle later. Equal times do not update.
  - Outputs hold; start edge → ARMED with a new random delay; stop edges are ignored.
- FOUL:
  - foul=1, stim_led=0; result_ms unchanged.
  - start edge → ARMED; foul clears.
- HISCORE:
  - high_enable=1.
  - show_high=0 → IDLE.
  - start and stop are ignored.
- reset asserted in any state returns everything to reset values immediately. high_score is also lost; this is intentional.
- NUM_PLAYERS=1: winner and foul_player are constant 0.

Test Plan:
- Common bench parameters: TICK_DIV=4, MIN_DELAY=3, DELAY_W=2, TIMEOUT=20, NUM_PLAYERS=4.
- Normal round: start edge, LFSR low bits=1 → delay 4 ms → stim_led rises after 16 clocks (±1 prescaler phase); stop[2] edge after 7 ticks → result_ms=7, winner=2, one-cycle result_valid, high_score=7 one cycle later.
- Foul: start, then stop[1] edge during ARMED → state 4, foul=1, foul_player=1, stim_led=0, high_score unchanged; next start edge → ARMED, foul=0.
- Simultaneous press: stop=4'b1010 rises in one cycle during TIMING at count 5 → winner=1, result_ms=5; a second round with result 9 leaves high_score=5; result 5 again → no update.
- Timeout: no stop for 20 ticks → result_ms=20, timeout=1, result_valid pulse, high_score unchanged.
- High-score mode: show_high=1 in IDLE → high_enable=1, start ignored; release → IDLE; clear_high in IDLE → high_score=all ones; start and show_high together → ARMED.
- Reset mid-TIMING: assert reset asynchronously (between clock edges) → state 0, stim_led=0, timing=0, high_score=all ones, without waiting for a clock.
